// File: rtl/fifo_sync_flags.sv
// Synchronous FIFO with status flags, sticky error flags and
// selectable first-word-fall-through or registered read port.
module fifo_sync_flags #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH-2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_wen,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ren,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_empty,
  output logic                  o_almost_full,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LVL =
    (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL =
    (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  wr_err;
  logic                  rd_err;
  logic                  ovf;
  logic                  udf;

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0])
              && (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);

  // flush swallows same-cycle requests, so they neither move nor err
  assign wr_ok  = i_wen && !full  && !i_flush;
  assign rd_ok  = i_ren && !empty && !i_flush;
  assign wr_err = i_wen && full   && !i_flush;
  assign rd_err = i_ren && empty  && !i_flush;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (i_flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= wr_err || (ovf && !i_clr_err);
      udf <= rd_err || (udf && !i_clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR_WIDTH-1:0]] <= i_data;
  end

  if (FWFT != 0) begin : g_fwft
    // gate with empty so unreset memory never leaks to o_data
    assign o_data  = empty ? '0 : mem[rptr[ADDR_WIDTH-1:0]];
    assign o_valid = !empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rdata  <= '0;
        rvalid <= 1'b0;
      end else begin
        rvalid <= rd_ok;
        if (rd_ok) rdata <= mem[rptr[ADDR_WIDTH-1:0]];
      end
    end

    assign o_data  = rdata;
    assign o_valid = rvalid;
  end

  assign o_count        = count;
  assign o_empty        = empty;
  assign o_full         = full;
  assign o_almost_full  = (count >= AF_LVL);
  assign o_almost_empty = (count <= AE_LVL);
  assign o_overflow     = ovf;
  assign o_underflow    = udf;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: registered-read and FWFT instances
// driven from one stimulus stream, with a read-data scoreboard.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic       flush = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] r_data, f_data;
  logic       r_valid, f_valid;
  logic       r_empty, f_empty;
  logic       r_full, f_full;
  logic       r_ae, f_ae;
  logic       r_af, f_af;
  logic [2:0] r_count, f_count;
  logic       r_ovf, f_ovf;
  logic       r_udf, f_udf;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  logic [7:0] sb[$];

  typedef struct {
    logic       wen;
    logic       ren;
    logic       flush;
    logic       clr;
    logic [7:0] data;
    logic [2:0] cnt;
    logic       emp;
    logic       full;
    logic       ae;
    logic       af;
    logic       ovf;
    logic       udf;
    logic       vld;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  fifo_sync_flags #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_THRESH(3),
    .AEMPTY_THRESH(1), .FWFT(0)
  ) u_reg (
    .clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_data(din),
    .i_ren(ren), .i_flush(flush), .i_clr_err(clr),
    .o_data(r_data), .o_valid(r_valid), .o_empty(r_empty),
    .o_full(r_full), .o_almost_empty(r_ae),
    .o_almost_full(r_af), .o_count(r_count),
    .o_overflow(r_ovf), .o_underflow(r_udf)
  );

  fifo_sync_flags #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_THRESH(3),
    .AEMPTY_THRESH(1), .FWFT(1)
  ) u_fwft (
    .clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_data(din),
    .i_ren(ren), .i_flush(flush), .i_clr_err(clr),
    .o_data(f_data), .o_valid(f_valid), .o_empty(f_empty),
    .o_full(f_full), .o_almost_empty(f_ae),
    .o_almost_full(f_af), .o_count(f_count),
    .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // drive one cycle, track the reference queue, score read data
  task automatic apply(input logic w, input logic r,
                       input logic fl, input logic c,
                       input logic [7:0] d);
    logic wr_acc;
    logic rd_acc;
    wen = w; ren = r; flush = fl; clr = c; din = d;
    if (fl) begin
      mq.delete();
    end else begin
      wr_acc = w && (mq.size() < 4);
      rd_acc = r && (mq.size() > 0);
      if (rd_acc) sb.push_back(mq.pop_front());
      if (wr_acc) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    if (r_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: o_valid=1 data=%0h none due", r_data);
      end else begin
        chk("rdata", r_data, sb.pop_front());
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_r_cnt"}, r_count, 0);
    chk({tag, "_r_data"}, r_data, 0);
    chk({tag, "_r_vld"}, r_valid, 0);
    chk({tag, "_r_emp"}, r_empty, 1);
    chk({tag, "_r_full"}, r_full, 0);
    chk({tag, "_r_ae"}, r_ae, 1);
    chk({tag, "_r_af"}, r_af, 0);
    chk({tag, "_r_ovf"}, r_ovf, 0);
    chk({tag, "_r_udf"}, r_udf, 0);
    chk({tag, "_f_cnt"}, f_count, 0);
    chk({tag, "_f_data"}, f_data, 0);
    chk({tag, "_f_vld"}, f_valid, 0);
    chk({tag, "_f_emp"}, f_empty, 1);
  endtask

  initial begin
    // wen ren flush clr data | cnt emp full ae af ovf udf vld
    tbl.push_back('{1,0,0,0,8'hA1, 1,0,0,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,8'hA2, 2,0,0,0,0,0,0,0});
    tbl.push_back('{1,0,0,0,8'hA3, 3,0,0,0,1,0,0,0});
    tbl.push_back('{1,0,0,0,8'hA4, 4,0,1,0,1,0,0,0});
    tbl.push_back('{0,1,0,0,8'h00, 3,0,0,0,1,0,0,1});
    tbl.push_back('{0,1,0,0,8'h00, 2,0,0,0,0,0,0,1});
    tbl.push_back('{0,1,0,0,8'h00, 1,0,0,1,0,0,0,1});
    tbl.push_back('{0,1,0,0,8'h00, 0,1,0,1,0,0,0,1});
    tbl.push_back('{0,0,0,0,8'h00, 0,1,0,1,0,0,0,0});
    tbl.push_back('{0,1,0,0,8'h00, 0,1,0,1,0,0,1,0});
    tbl.push_back('{1,1,0,0,8'hC1, 1,0,0,1,0,0,1,0});
    tbl.push_back('{1,0,0,0,8'hC2, 2,0,0,0,0,0,1,0});
    tbl.push_back('{1,0,0,0,8'hC3, 3,0,0,0,1,0,1,0});
    tbl.push_back('{1,0,0,0,8'hC4, 4,0,1,0,1,0,1,0});
    tbl.push_back('{1,1,0,0,8'hD1, 3,0,0,0,1,1,1,1});
    tbl.push_back('{0,0,0,1,8'h00, 3,0,0,0,1,0,0,0});
    tbl.push_back('{0,1,0,0,8'h00, 2,0,0,0,0,0,0,1});
    tbl.push_back('{0,1,0,0,8'h00, 1,0,0,1,0,0,0,1});
    tbl.push_back('{0,1,0,0,8'h00, 0,1,0,1,0,0,0,1});
    tbl.push_back('{1,0,0,0,8'hE1, 1,0,0,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,8'hE2, 2,0,0,0,0,0,0,0});
    tbl.push_back('{1,0,0,0,8'hE3, 3,0,0,0,1,0,0,0});
    tbl.push_back('{1,1,1,0,8'hE4, 0,1,0,1,0,0,0,0});
    tbl.push_back('{0,1,0,1,8'h00, 0,1,0,1,0,0,1,0});
    tbl.push_back('{0,0,0,1,8'h00, 0,1,0,1,0,0,0,0});

    #2;
    check_reset("rst0");
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].wen, tbl[i].ren, tbl[i].flush,
            tbl[i].clr, tbl[i].data);
      chk($sformatf("v%0d_cnt", i), r_count, tbl[i].cnt);
      chk($sformatf("v%0d_emp", i), r_empty, tbl[i].emp);
      chk($sformatf("v%0d_full", i), r_full, tbl[i].full);
      chk($sformatf("v%0d_ae", i), r_ae, tbl[i].ae);
      chk($sformatf("v%0d_af", i), r_af, tbl[i].af);
      chk($sformatf("v%0d_ovf", i), r_ovf, tbl[i].ovf);
      chk($sformatf("v%0d_udf", i), r_udf, tbl[i].udf);
      chk($sformatf("v%0d_vld", i), r_valid, tbl[i].vld);
      chk($sformatf("v%0d_fcnt", i), f_count, tbl[i].cnt);
    end

    // streaming at count 2 across pointer wrap
    apply(1, 0, 0, 0, 8'hF0);
    apply(1, 0, 0, 0, 8'hF1);
    for (int i = 0; i < 20; i++) begin
      apply(1, 1, 0, 0, 8'(8'h10 + i));
      chk($sformatf("s%0d_cnt", i), r_count, 2);
      chk($sformatf("s%0d_fcnt", i), f_count, 2);
      chk($sformatf("s%0d_vld", i), r_valid, 1);
    end

    // first-word-fall-through visibility
    apply(0, 0, 1, 0, 8'h00);
    chk("fw_flush_emp", f_empty, 1);
    apply(1, 0, 0, 0, 8'h5C);
    chk("fw_vld", f_valid, 1);
    chk("fw_data", f_data, 8'h5C);
    chk("fw_r_vld", r_valid, 0);
    apply(0, 0, 0, 0, 8'h00);
    chk("fw_hold_vld", f_valid, 1);
    chk("fw_hold_data", f_data, 8'h5C);
    apply(0, 1, 0, 0, 8'h00);
    chk("fw_pop_emp", f_empty, 1);
    chk("fw_pop_vld", f_valid, 0);
    chk("fw_pop_r_vld", r_valid, 1);

    // asynchronous reset in the middle of traffic
    apply(1, 0, 0, 0, 8'h61);
    apply(1, 0, 0, 0, 8'h62);
    apply(1, 0, 0, 0, 8'h63);
    apply(1, 0, 0, 0, 8'h64);
    apply(1, 0, 0, 0, 8'h65);
    chk("mid_ovf", r_ovf, 1);
    apply(1, 1, 0, 0, 8'h66);
    chk("mid_cnt", r_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst1");
    mq.delete();
    sb.delete();
    wen = 0; ren = 0; flush = 0; clr = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    apply(1, 0, 0, 0, 8'h77);
    chk("post_cnt", r_count, 1);
    chk("post_fdata", f_data, 8'h77);
    apply(0, 1, 0, 0, 8'h00);
    chk("post_vld", r_valid, 1);
    chk("post_data", r_data, 8'h77);
    apply(0, 0, 0, 0, 8'h00);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
FIFO_SYNC_FLAGS -- requirements
Module: fifo_sync_flags

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each data word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: depth = 2**ADDR_WIDTH words; legal range >= 1.
REQ-003 SHALL have parameter AFULL_THRESH, default 2**ADDR_WIDTH-2: almost-full level; legal range 1..2**ADDR_WIDTH.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2: almost-empty level; legal range 0..2**ADDR_WIDTH-1.
REQ-005 SHALL have parameter FWFT, default 0: 1 = first-word-fall-through, 0 = registered read.
REQ-006 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-007 SHALL have port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-008 SHALL have ports i_wen (input, 1: write request) and i_data (input, DATA_WIDTH: write data).
REQ-009 SHALL have port i_ren, input, 1: read request.
REQ-010 SHALL have port i_flush, input, 1: synchronous flush.
REQ-011 SHALL have port i_clr_err, input, 1: clears sticky error flags.
REQ-012 SHALL have ports o_data (output, DATA_WIDTH: read data) and o_valid (output, 1: o_data valid).
REQ-013 SHALL have ports o_empty, o_full, o_almost_empty, o_almost_full (outputs, 1 each: status).
REQ-014 SHALL have port o_count, output, ADDR_WIDTH+1: words stored, 0..2**ADDR_WIDTH.
REQ-015 SHALL have ports o_overflow and o_underflow, outputs, 1 each: sticky error flags.

Function
REQ-016 SHALL accept a write iff i_wen=1 and o_full=0; the accepted word is stored at the write pointer, which increments.
REQ-017 SHALL accept a read iff i_ren=1 and o_empty=0; the read pointer increments.
REQ-018 SHALL use ADDR_WIDTH+1-bit pointers wrapping modulo 2**(ADDR_WIDTH+1); the MSB distinguishes full from empty.
REQ-019 SHALL assert o_empty when the pointers are equal, and o_full when the low ADDR_WIDTH bits are equal and the MSBs differ.
REQ-020 SHALL drive o_count = write pointer - read pointer, modulo 2**(ADDR_WIDTH+1).
REQ-021 SHALL drive o_almost_full = (o_count >= AFULL_THRESH) and o_almost_empty = (o_count <= AEMPTY_THRESH).
REQ-022 SHALL derive all status outputs from registered state only, with no combinational path from i_wen or i_ren.
REQ-023 SHALL, on simultaneous accepted read and write, leave o_count unchanged, including at wrap-around.
REQ-024 SHALL, at full with i_wen=1 and i_ren=1, accept the read, reject the write and set o_overflow.
REQ-025 SHALL, at empty with i_wen=1 and i_ren=1, accept the write, reject the read and set o_underflow; no write-to-read bypass.
REQ-026 SHALL, when FWFT=1, drive o_data = word at the read pointer, o_valid = !o_empty, and i_ren acts as the pop.
REQ-027 SHALL, when FWFT=0, register the word on an accepted read: o_data updates on the next edge, o_valid=1 for exactly that cycle, and o_data holds its value otherwise.
REQ-028 SHALL set o_overflow on a rejected write and o_underflow on a rejected read; both stay set until cleared.
REQ-029 SHALL clear both error flags on i_clr_err=1 at the next edge; a same-cycle new error takes priority and keeps the flag set.
REQ-030 SHALL, on i_flush=1, zero both pointers and o_valid at the next edge, ignoring same-cycle i_wen/i_ren; flush itself does not change error flags or memory contents.

Reset
REQ-031 SHALL, while i_rst_n=0, immediately drive pointers=0, o_count=0, o_data=0, o_valid=0, o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0, o_overflow=0, o_underflow=0.
REQ-032 SHALL leave memory contents unreset and resume normal operation on the first rising clk edge after i_rst_n deasserts.
REQ-033 SHALL, on reset mid-operation, discard all stored words; the next read returns only data written after reset.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, AFULL_THRESH=3, AEMPTY_THRESH=1)
REQ-034 SHALL cover: write 0xA1..0xA4, FWFT=0 -> o_count 1,2,3,4; o_almost_full at count 3; o_full at 4; four reads -> 0xA1..0xA4, each with o_valid pulse one cycle after its read.
REQ-035 SHALL cover: at full, i_wen and i_ren together -> read of head accepted, write rejected, o_count=3, o_overflow=1; i_clr_err -> o_overflow=0.
REQ-036 SHALL cover: at empty, i_ren -> o_underflow=1, o_valid stays 0; i_wen+i_ren together -> o_count=1, o_underflow stays 1.
REQ-037 SHALL cover: 20 cycles of continuous simultaneous write/read at count 2 -> o_count stays 2 across pointer wrap and data order is preserved.
REQ-038 SHALL cover: FWFT=1, write 0x5C -> next cycle o_valid=1, o_data=0x5C with no i_ren; i_ren -> o_empty=1, o_valid=0.
REQ-039 SHALL cover: 3 words stored, then i_flush -> o_count=0, o_empty=1; separately, i_rst_n low mid-burst -> all REQ-031 values asynchronously, before the next clk edge.
